// File: rtl/tc_ar_splitter.sv
// tc_ar_splitter: splits a read command into AXI4 INCR AR bursts, throttled by bursts in flight.
// Define TC_AR_4K_SPLIT_EN to additionally stop every burst at a 4 KB boundary.
module tc_ar_splitter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int MAX_BURST  = 256,
    parameter int MAX_OUTST  = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [15:0]           cmd_beats,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rvalid,
    input  logic                  m_axi_rready,
    input  logic                  m_axi_rlast,
    output logic                  busy,
    output logic                  done
);
    localparam int BPB = DATA_WIDTH / 8;
    localparam int SZ  = $clog2(BPB);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d, nxt_addr, step;
    logic [7:0]            arlen_q, arlen_d;
    logic [15:0]           rem_q, rem_d, nxt_rem, cap, lim;
    logic [3:0]            outst_q, outst_d;
    logic [8:0]            cur_len;
    logic                  arvalid_q, arvalid_d, busy_q, busy_d, done_q, done_d, ready_q, ready_d;
    logic                  accept, hs, rl, load;

    // araddr_q/arlen_q always describe the next burst to issue; rem_q still includes it.
    always_comb begin
        accept   = (state_q == IDLE) & cmd_valid;
        hs       = arvalid_q & m_axi_arready;
        rl       = m_axi_rvalid & m_axi_rready & m_axi_rlast & (outst_q != 4'd0);
        cur_len  = 9'(arlen_q) + 9'd1;
        step     = ADDR_WIDTH'(cur_len) << SZ;
        nxt_addr = accept ? (cmd_addr & ~ADDR_WIDTH'(BPB - 1)) : hs ? araddr_q + step : araddr_q;
        nxt_rem  = accept ? cmd_beats : hs ? rem_q - 16'(cur_len) : rem_q;
        outst_d  = outst_q + 4'(hs) - 4'(rl);
    end

`ifdef TC_AR_4K_SPLIT_EN
    assign cap = 16'((13'd4096 - {1'b0, nxt_addr[11:0]}) >> SZ);
`else
    assign cap = 16'(MAX_BURST);
`endif

    always_comb begin
        lim = (nxt_rem > 16'(MAX_BURST)) ? 16'(MAX_BURST) : nxt_rem;
        lim = (cap < lim) ? cap : lim;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (accept && cmd_beats != 16'd0) ? ISSUE : IDLE;
            ISSUE:   state_d = (nxt_rem == 16'd0) ? DRAIN : ISSUE;
            DRAIN:   state_d = (outst_d == 4'd0) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load      = state_d == ISSUE;
        arvalid_d = load & (outst_d < 4'(MAX_OUTST));
        araddr_d  = load ? nxt_addr : araddr_q;
        arlen_d   = load ? 8'(lim - 16'd1) : arlen_q;
        rem_d     = nxt_rem;
        busy_d    = state_d != IDLE;
        ready_d   = state_d == IDLE;
        done_d    = (accept & (cmd_beats == 16'd0)) | ((state_q == DRAIN) & (state_d == IDLE));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            araddr_q  <= '0;
            arlen_q   <= '0;
            rem_q     <= '0;
            outst_q   <= '0;
            arvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            rem_q     <= rem_d;
            outst_q   <= outst_d;
            arvalid_q <= arvalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign cmd_ready     = ready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(SZ);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_tc_ar_splitter.sv
// tb_tc_ar_splitter: directed checks of burst splitting, throttling, handshake stability and reset.
module tb_tc_ar_splitter;
`ifdef TC_AR_4K_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready, m_axi_rlast;
    logic        busy, done;

    int          n_chk = 0, n_err = 0, base = 0, n_r = 0, dc = 0;
    logic [31:0] ar_a[$];
    logic [7:0]  ar_l[$];
    logic [31:0] ea[$];
    logic [7:0]  el[$];
    int          done_cnt = 0;

    always #5 aclk = ~aclk;

    tc_ar_splitter dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rlast(m_axi_rlast),
        .busy(busy), .done(done)
    );

    always @(posedge aclk) begin
        if (aresetn) begin
            if (m_axi_arvalid && m_axi_arready) begin
                ar_a.push_back(m_axi_araddr);
                ar_l.push_back(m_axi_arlen);
            end
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic r_drive(input logic v);
        m_axi_rvalid = v;
        m_axi_rready = v;
        m_axi_rlast  = v;
    endtask

    task automatic do_cmd(input logic [31:0] a, input logic [15:0] b);
        check("cmd_ready_idle", cmd_ready, 1);
        base      = ar_a.size();
        n_r       = 0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_beats = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Return one rlast per issued burst until done shows up, then confirm its timing.
    task automatic drain(input int n_exp);
        logic prev_r = 1'b0;
        logic got = 1'b0;
        for (int c = 0; c < 2000 && !got; c++) begin
            if (done) begin
                got = 1'b1;
                check("done_after_last_rlast", prev_r, 1);
                check("rlast_count_at_done", n_r, n_exp);
                check("busy_at_done", busy, 0);
            end else begin
                prev_r = (ar_a.size() - base) > n_r;
                r_drive(prev_r);
                if (prev_r) n_r++;
                tick();
            end
        end
        r_drive(1'b0);
        check("done_seen", got, 1);
        check("ar_count", ar_a.size() - base, n_exp);
        tick();
        check("done_one_cycle", done, 0);
    endtask

    task automatic check_ar(input int i, input logic [31:0] a, input logic [7:0] l);
        if (base + i < ar_a.size()) begin
            check($sformatf("ar%0d_addr", i), ar_a[base+i], a);
            check($sformatf("ar%0d_len", i), 32'(ar_l[base+i]), 32'(l));
        end else begin
            check($sformatf("ar%0d_present", i), ar_a.size() - base, i + 1);
        end
    endtask

    task automatic check_list();
        for (int i = 0; i < ea.size(); i++) check_ar(i, ea[i], el[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
        m_axi_arready = 1'b0;
        r_drive(1'b0);
        aresetn = 1'b0;
        repeat (2) tick();
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_araddr", m_axi_araddr, 0);
        check("rst_arlen", m_axi_arlen, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("arsize", m_axi_arsize, 5);
        check("arburst", m_axi_arburst, 1);
        aresetn = 1'b1;
        tick();
        check("cmd_ready_after_rst", cmd_ready, 1);

        // single burst
        m_axi_arready = 1'b1;
        do_cmd(32'h1000, 16'd8);
        check("busy_after_accept", busy, 1);
        check("cmd_ready_busy", cmd_ready, 0);
        drain(1);
        check_ar(0, 32'h1000, 8'd7);

        // long command split by MAX_BURST and, optionally, 4 KB
        do_cmd(32'h0, 16'd600);
        if (SPLIT) begin
            ea = '{32'h0, 32'h1000, 32'h2000, 32'h3000, 32'h4000};
            el = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd87};
        end else begin
            ea = '{32'h0, 32'h2000, 32'h4000};
            el = '{8'd255, 8'd255, 8'd87};
        end
        drain(ea.size());
        check_list();

        // unaligned start just below a 4 KB boundary
        do_cmd(32'h0F8F, 16'd10);
        if (SPLIT) begin
            ea = '{32'h0F80, 32'h1000};
            el = '{8'd3, 8'd5};
        end else begin
            ea = '{32'h0F80};
            el = '{8'd9};
        end
        drain(ea.size());
        check_list();

        // zero-beat command
        do_cmd(32'h5000, 16'd0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_cmd_ready", cmd_ready, 1);
        tick();
        check("zero_done_end", done, 0);
        check("zero_no_ar", ar_a.size() - base, 0);

        // outstanding limit, with a rejected command while busy
        do_cmd(32'h0, 16'd1200);
        cmd_valid = 1'b1; cmd_addr = 32'h7000; cmd_beats = 16'd5;
        repeat (10) tick();
        check("busy_cmd_ready", cmd_ready, 0);
        cmd_valid = 1'b0;
        check("throttle_count", ar_a.size() - base, 4);
        check("throttle_arvalid", m_axi_arvalid, 0);
        check("throttle_busy", busy, 1);
        r_drive(1'b1);
        n_r = 1;
        tick();
        r_drive(1'b0);
        check("fifth_arvalid", m_axi_arvalid, 1);
        check("fifth_araddr", m_axi_araddr, SPLIT ? 32'h4000 : 32'h8000);
        check("fifth_arlen", m_axi_arlen, SPLIT ? 32'd127 : 32'd175);
        drain(SPLIT ? 10 : 5);
        check_ar(SPLIT ? 9 : 4, SPLIT ? 32'h9000 : 32'h8000, SPLIT ? 8'd47 : 8'd175);

        // stalled AR stays stable; simultaneous handshake and rlast
        m_axi_arready = 1'b0;
        do_cmd(32'h0, 16'd1200);
        for (int i = 0; i < 5; i++) begin
            check("stall_arvalid", m_axi_arvalid, 1);
            check("stall_araddr", m_axi_araddr, 0);
            check("stall_arlen", m_axi_arlen, SPLIT ? 32'd127 : 32'd255);
            tick();
        end
        check("stall_no_ar", ar_a.size() - base, 0);
        m_axi_arready = 1'b1;
        repeat (3) tick();
        check("three_issued", ar_a.size() - base, 3);
        r_drive(1'b1);
        n_r = 1;
        tick();
        r_drive(1'b0);
        check("hs_rlast_same_arvalid", m_axi_arvalid, 1);
        check("hs_rlast_same_count", ar_a.size() - base, 4);
        tick();
        check("limit_reached_arvalid", m_axi_arvalid, 0);
        check("limit_reached_count", ar_a.size() - base, 5);
        drain(SPLIT ? 10 : 5);
        check_ar(0, 32'h0, SPLIT ? 8'd127 : 8'd255);

        // reset in the middle of ISSUE
        m_axi_arready = 1'b0;
        do_cmd(32'h3000, 16'd64);
        check("pre_rst_arvalid", m_axi_arvalid, 1);
        #2;
        aresetn = 1'b0;
        #1;
        check("mid_rst_arvalid", m_axi_arvalid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        dc = done_cnt;
        repeat (2) tick();
        aresetn = 1'b1;
        r_drive(1'b1);
        tick();
        r_drive(1'b0);
        repeat (3) tick();
        check("no_done_after_rst", done_cnt, dc);
        m_axi_arready = 1'b1;
        do_cmd(32'h1000, 16'd8);
        drain(1);
        check_ar(0, 32'h1000, 8'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_err);
        $finish;
    end
endmodule
